// File: rtl/imm_pkg.sv
// imm_pkg: formats, opcodes and entry type for the immediate pipeline.
// IMM_AUTODECODE_EN switches format selection to the opcode field.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I  = 3'd0,
    IMM_S  = 3'd1,
    IMM_B  = 3'd2,
    IMM_U  = 3'd3,
    IMM_J  = 3'd4,
    IMM_SH = 3'd5
  } imm_src_e;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;

  localparam int IMM_MAX_W = 64;
  localparam int TAG_MAX_W = 16;

  // Widest-case entry shape shared with neighbouring stages.
  typedef struct packed {
    logic [IMM_MAX_W-1:0] imm;
    logic [TAG_MAX_W-1:0] tag;
    logic                 err;
  } imm_entry_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: upstream and downstream valid/ready bundle.
// Optional IMM_AUTODECODE_EN leaves in_immsrc present but unused.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_immsrc;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid,
    output in_instr,
    output in_immsrc,
    output in_tag,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_imm,
    input  out_tag,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_instr,
    input  in_immsrc,
    input  in_tag,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_imm,
    output out_tag,
    output out_err
  );

endinterface

// File: rtl/imm_extract.sv
// imm_extract: combinational format mux for all base immediates.
// IMM_AUTODECODE_EN derives the format from instr[6:0].
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  input  logic [2:0]      i_immsrc,
  output logic [XLEN-1:0] o_imm,
  output logic            o_err
);

  logic [31:0] w_i;
  logic [31:0] w_s;
  logic [31:0] w_b;
  logic [31:0] w_u;
  logic [31:0] w_j;
  logic [5:0]  w_sh;
  imm_src_e    w_src;
  logic        w_bad;

  assign w_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_s = {{20{i_instr[31]}}, i_instr[31:25],
                i_instr[11:7]};
  assign w_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_u = {i_instr[31:12], 12'b0};
  assign w_j = {{11{i_instr[31]}}, i_instr[31],
                i_instr[19:12], i_instr[20],
                i_instr[30:21], 1'b0};

  // RV64 shifts take one more shamt bit.
  assign w_sh = (XLEN == 64) ? i_instr[25:20]
                             : {1'b0, i_instr[24:20]};

`ifdef IMM_AUTODECODE_EN
  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic [2:0] w_unused_src;

  assign w_op         = i_instr[6:0];
  assign w_f3         = i_instr[14:12];
  assign w_unused_src = i_immsrc;

  always_comb begin
    w_src = IMM_I;
    w_bad = 1'b0;
    unique case (1'b1)
      (w_op == OP_IMM):
        w_src = (w_f3 == 3'b001 || w_f3 == 3'b101)
              ? IMM_SH : IMM_I;
      (w_op == LOAD),
      (w_op == JALR),
      (w_op == SYSTEM): w_src = IMM_I;
      (w_op == STORE):  w_src = IMM_S;
      (w_op == BRANCH): w_src = IMM_B;
      (w_op == LUI),
      (w_op == AUIPC):  w_src = IMM_U;
      (w_op == JAL):    w_src = IMM_J;
      default:          w_bad = 1'b1;
    endcase
  end
`else
  logic [6:0] w_unused_op;

  assign w_unused_op = i_instr[6:0];
  assign w_src       = imm_src_e'(i_immsrc);
  assign w_bad       = 1'b0;
`endif

  always_comb begin
    o_imm = '0;
    o_err = 1'b0;
    if (w_bad) begin
      o_err = 1'b1;
    end else begin
      unique case (w_src)
        IMM_I:   o_imm = XLEN'($signed(w_i));
        IMM_S:   o_imm = XLEN'($signed(w_s));
        IMM_B:   o_imm = XLEN'($signed(w_b));
        IMM_U:   o_imm = XLEN'($signed(w_u));
        IMM_J:   o_imm = XLEN'($signed(w_j));
        IMM_SH:  o_imm = XLEN'(w_sh);
        default: o_err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate generator behind an output reg + skid entry.
// Build with IMM_AUTODECODE_EN to decode the format from the opcode.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  logic [XLEN-1:0] w_imm;
  logic            w_err;
  entry_t          w_new;
  entry_t          r_main;
  entry_t          r_skid;
  logic            r_main_v;
  logic            r_skid_v;
  logic            w_acc;
  logic            w_pop;
  logic            w_free;

  imm_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .i_instr  (bus.in_instr),
    .i_immsrc (bus.in_immsrc),
    .o_imm    (w_imm),
    .o_err    (w_err)
  );

  assign w_new = '{imm: w_imm, tag: bus.in_tag, err: w_err};

  // in_ready depends only on state, never on out_ready.
  assign bus.in_ready = !r_skid_v;

  assign w_acc  = bus.in_valid && !r_skid_v && !flush;
  assign w_pop  = r_main_v && bus.out_ready;
  assign w_free = !r_main_v || w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main   <= '0;
    end else if (flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (w_free) begin
      r_main_v <= r_skid_v || w_acc;
      r_skid_v <= 1'b0;
      if (r_skid_v) begin
        r_main <= r_skid;
      end else if (w_acc) begin
        r_main <= w_new;
      end
    end else if (w_acc) begin
      r_skid_v <= 1'b1;
    end
  end

  // Skid payload is qualified by r_skid_v, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!w_free && w_acc) begin
      r_skid <= w_new;
    end
  end

  assign bus.out_valid = r_main_v;
  assign bus.out_imm   = r_main.imm;
  assign bus.out_tag   = r_main.tag;
  assign bus.out_err   = r_main.err;

endmodule
